// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI note parser: FSM states, status constants
// and the packing of the 20-bit {chan, pitch, velocity} message.
package midi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NOTE_D1,
        ST_NOTE_D2,
        ST_SKIP_D1,
        ST_SKIP_D2,
        ST_SYSEX
    } state_e;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] BEND     = 4'hE;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    localparam int unsigned MSG_W     = 20;
    localparam int unsigned CHAN_MSB  = 19;
    localparam int unsigned CHAN_LSB  = 16;
    localparam int unsigned PITCH_MSB = 15;
    localparam int unsigned PITCH_LSB = 8;
    localparam int unsigned VEL_MSB   = 7;
    localparam int unsigned VEL_LSB   = 0;

    function automatic logic [MSG_W-1:0] pack_msg(input logic [3:0] chan,
                                                  input logic [7:0] pitch,
                                                  input logic [7:0] vel);
        logic [MSG_W-1:0] m;
        m = '0;
        m[CHAN_MSB:CHAN_LSB]   = chan;
        m[PITCH_MSB:PITCH_LSB] = pitch;
        m[VEL_MSB:VEL_LSB]     = vel;
        return m;
    endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// Combinational decode of one received MIDI byte into its protocol class
// and, for non-note channel messages, the number of data bytes that follow.
module midi_byte_classify
    import midi_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_data_o,
    output logic       is_chan_status_o,
    output logic       is_common_o,
    output logic       is_realtime_o,
    output logic [1:0] skip_len_o
);

    always_comb begin
        is_data_o        = ~byte_i[7];
        is_chan_status_o = byte_i[7] && (byte_i < SYSEX_START);
        is_common_o      = (byte_i >= SYSEX_START) && (byte_i <= SYSEX_END);
        is_realtime_o    = (byte_i >= RT_MIN);
        skip_len_o       = 2'd0;
        // Note On/Off report 0 here; the parser sends them to the note path.
        if (is_chan_status_o) begin
            case (byte_i[7:4])
                POLY_AT, CC, BEND: skip_len_o = 2'd2;
                PROG, CH_AT:       skip_len_o = 2'd1;
                default:           skip_len_o = 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser with running status. Emits normalised note
// messages (Note Off becomes velocity 0); all other traffic is swallowed.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int unsigned NUM_CH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [7:0]       Rx_data,
    input  logic             Rx_valid,
    output logic [MSG_W-1:0] MIDI_msg,
    output logic             Msg_valid,
    output logic             Err,
    output logic             Drop
);

    logic       is_data;
    logic       is_chan_status;
    logic       is_common;
    logic       is_realtime;
    logic [1:0] skip_len;

    midi_byte_classify u_classify (
        .byte_i           (Rx_data),
        .is_data_o        (is_data),
        .is_chan_status_o (is_chan_status),
        .is_common_o      (is_common),
        .is_realtime_o    (is_realtime),
        .skip_len_o       (skip_len)
    );

    state_e           state_q, state_d;
    logic [3:0]       status_q, status_d;
    logic [3:0]       chan_q, chan_d;
    logic             skip2_q, skip2_d;
    logic [7:0]       pitch_q, pitch_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic             msg_valid_q, msg_valid_d;
    logic             err_q, err_d;
    logic             drop_q, drop_d;
    logic [7:0]       vel;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            status_q    <= '0;
            chan_q      <= '0;
            skip2_q     <= 1'b0;
            pitch_q     <= '0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            chan_q      <= chan_d;
            skip2_q     <= skip2_d;
            pitch_q     <= pitch_d;
            msg_q       <= msg_d;
            msg_valid_q <= msg_valid_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        chan_d      = chan_q;
        skip2_d     = skip2_q;
        pitch_d     = pitch_q;
        msg_d       = msg_q;
        msg_valid_d = 1'b0;
        err_d       = 1'b0;
        drop_d      = 1'b0;
        vel         = (status_q == NOTE_ON) ? Rx_data : 8'h00;

        if (Rx_valid && !is_realtime) begin
            if (is_data) begin
                case (state_q)
                    ST_IDLE:    err_d = 1'b1;
                    ST_NOTE_D1: begin
                        pitch_d = Rx_data;
                        state_d = ST_NOTE_D2;
                    end
                    ST_NOTE_D2: begin
                        state_d = ST_NOTE_D1;
                        if (32'(chan_q) < NUM_CH) begin
                            msg_d       = pack_msg(chan_q, pitch_q, vel);
                            msg_valid_d = 1'b1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                    ST_SKIP_D1: state_d = skip2_q ? ST_SKIP_D2 : ST_SKIP_D1;
                    ST_SKIP_D2: state_d = ST_SKIP_D1;
                    default:    state_d = state_q;
                endcase
            end else begin
                // A status byte landing mid-message aborts it, yet is still adopted.
                err_d = (state_q == ST_NOTE_D2) || (state_q == ST_SKIP_D2);
                if (is_chan_status) begin
                    status_d = Rx_data[7:4];
                    chan_d   = Rx_data[3:0];
                    skip2_d  = (skip_len == 2'd2);
                    state_d  = (skip_len == 2'd0) ? ST_NOTE_D1 : ST_SKIP_D1;
                end else if (is_common) begin
                    status_d = '0;
                    chan_d   = '0;
                    skip2_d  = 1'b0;
                    state_d  = (Rx_data == SYSEX_START) ? ST_SYSEX : ST_IDLE;
                end
            end
        end
    end

    assign MIDI_msg  = msg_q;
    assign Msg_valid = msg_valid_q;
    assign Err       = err_q;
    assign Drop      = drop_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Self-checking bench: directed plan cases plus a random byte stream, all
// checked against a message-counting reference model of the MIDI protocol.
module tb_midi_msg_parser;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [7:0]  Rx_data = '0;
    logic        Rx_valid = 1'b0;
    logic [19:0] MIDI_msg;
    logic        Msg_valid;
    logic        Err;
    logic        Drop;

    midi_msg_parser #(.NUM_CH(8)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Rx_data   (Rx_data),
        .Rx_valid  (Rx_valid),
        .MIDI_msg  (MIDI_msg),
        .Msg_valid (Msg_valid),
        .Err       (Err),
        .Drop      (Drop)
    );

    always #5 Clk = ~Clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: running status byte (0 = none), count of data bytes
    // gathered toward the current message, and whether we are inside SysEx.
    logic [7:0]  m_rs;
    int unsigned m_cnt;
    logic [7:0]  m_d0;
    bit          m_sysex;
    logic [19:0] e_msg;
    bit          e_valid, e_err, e_drop;

    function automatic int unsigned data_needed(input logic [7:0] s);
        case (s[7:4])
            4'hC, 4'hD: return 1;
            default:    return 2;
        endcase
    endfunction

    task automatic model_reset();
        m_rs = 8'h00; m_cnt = 0; m_d0 = 8'h00; m_sysex = 0;
        e_msg = '0; e_valid = 0; e_err = 0; e_drop = 0;
    endtask

    task automatic model_apply(input logic v, input logic [7:0] b);
        e_valid = 0; e_err = 0; e_drop = 0;
        if (!v || b >= 8'hF8) return;
        if (b[7]) begin
            if (m_rs != 8'h00 && m_cnt != 0) e_err = 1;
            m_cnt = 0;
            if (b < 8'hF0) begin
                m_rs = b; m_sysex = 0;
            end else begin
                m_rs = 8'h00; m_sysex = (b == 8'hF0);
            end
        end else if (m_rs == 8'h00) begin
            if (!m_sysex) e_err = 1;
        end else begin
            if (m_cnt == 0) m_d0 = b;
            m_cnt++;
            if (m_cnt == data_needed(m_rs)) begin
                m_cnt = 0;
                if (m_rs[7:4] == 4'h8 || m_rs[7:4] == 4'h9) begin
                    if (m_rs[3:0] < 4'd8) begin
                        e_valid = 1;
                        e_msg = {m_rs[3:0], m_d0, (m_rs[7:4] == 4'h9) ? b : 8'h00};
                    end else begin
                        e_drop = 1;
                    end
                end
            end
        end
    endtask

    // Drive one cycle (called at a negedge), then check just after the posedge.
    task automatic step(input logic v, input logic [7:0] b);
        Rx_valid = v;
        Rx_data  = b;
        model_apply(v, b);
        @(posedge Clk);
        #1;
        check("msg_valid", 32'(Msg_valid), 32'(e_valid));
        check("err",       32'(Err),       32'(e_err));
        check("drop",      32'(Drop),      32'(e_drop));
        check("midi_msg",  32'(MIDI_msg),  32'(e_msg));
        @(negedge Clk);
        Rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    logic [7:0] b;

    initial begin
        model_reset();
        repeat (3) @(negedge Clk);
        check("reset_msg",   32'(MIDI_msg),  32'h0);
        check("reset_valid", 32'(Msg_valid), 32'h0);
        check("reset_err",   32'(Err),       32'h0);
        check("reset_drop",  32'(Drop),      32'h0);
        Rst_n = 1'b1;
        @(negedge Clk);

        send(8'h92); send(8'h3C); send(8'h64);
        check("plan_note_on", 32'(MIDI_msg), 32'h23C64);
        step(1'b0, 8'h00);
        check("plan_pulse_one_cycle", 32'(Msg_valid), 32'h0);

        send(8'h90); send(8'h40); send(8'h7F);
        check("plan_rs_first", 32'(MIDI_msg), 32'h0407F);
        send(8'h41); send(8'h00);
        check("plan_rs_second", 32'(MIDI_msg), 32'h04100);

        send(8'h85); send(8'h30); send(8'h55);
        check("plan_note_off", 32'(MIDI_msg), 32'h53000);

        send(8'h91); send(8'h3C); send(8'hF8); send(8'h50);
        check("plan_realtime", 32'(MIDI_msg), 32'h13C50);

        send(8'h9A); send(8'h3C); send(8'h40);
        check("plan_drop", 32'(Drop), 32'h1);
        check("plan_drop_hold", 32'(MIDI_msg), 32'h13C50);

        send(8'hF1); send(8'h3C);
        check("plan_idle_err", 32'(Err), 32'h1);

        send(8'h90); send(8'h3C); send(8'hB0);
        check("plan_abort_err", 32'(Err), 32'h1);
        send(8'h07); send(8'h64);

        send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h40);
        check("plan_sysex_err", 32'(Err), 32'h1);

        send(8'h93);
        #2 Rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_msg",   32'(MIDI_msg),  32'h0);
        check("async_rst_pulse", 32'({Msg_valid, Err, Drop}), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        send(8'h3C);
        check("plan_rst_err", 32'(Err), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: b = 8'($urandom_range(0, 127));
                5, 6:          b = {4'($urandom_range(8, 9)), 4'($urandom_range(0, 15))};
                7:             b = 8'($urandom_range(8'hA0, 8'hEF));
                8:             b = 8'($urandom_range(8'hF0, 8'hF7));
                default:       b = 8'($urandom_range(8'hF8, 8'hFF));
            endcase
            step(($urandom_range(0, 3) != 0), b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Byte-stream MIDI parser between the UART receiver and the channel demultiplexer.
- Consumes one received byte per strobe and tracks running status.
- Emits 20-bit note messages {channel[3:0], pitch[7:0], velocity[7:0]}: bits [19:16] drive the demux select and bits [15:0] drive its data input.
- Note Off is normalised to velocity 0, so downstream only ever sees "note with velocity"; non-note traffic is consumed silently.

Parameters:
- NUM_CH, 8, channels accepted (0..NUM_CH-1); notes on higher channels are dropped with Drop pulse.

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- Rx_data  in  8  received MIDI byte.
- Rx_valid  in  1  single-cycle strobe, Rx_data valid this cycle.
- MIDI_msg  out  20  {chan, pitch, velocity}; holds last emitted message.
- Msg_valid  out  1  one-cycle pulse when MIDI_msg updates.
- Err  out  1  one-cycle pulse on protocol error.
- Drop  out  1  one-cycle pulse on a well-formed note for a channel >= NUM_CH.

Behaviour:
- Reset (async assert, sync release):
  - MIDI_msg=0, Msg_valid=0, Err=0, Drop=0.
  - state=IDLE, running status cleared.
  - Reset mid-message discards the partial message; no output pulse.
- Bytes are processed only when Rx_valid=1; otherwise state and outputs hold, and pulses return to 0.
- Byte classes:
  - Data: bit7=0.
  - Channel status: 0x80-0xEF.
  - System common/SysEx: 0xF0-0xF7.
  - Real-time: 0xF8-0xFF.
- Real-time bytes: ignored entirely. No state change and no Err, even in the middle of a message.
- States:
  - IDLE: no running status.
  - NOTE_D1: expecting pitch.
  - NOTE_D2: expecting velocity.
  - SKIP_D1, SKIP_D2: consuming data bytes of non-note channel messages.
  - SYSEX: discarding until 0xF7 or any status byte.
- Status handling, in any state:
  - 0x8n/0x9n: store status and channel n, go to NOTE_D1.
  - 0xAn/0xBn/0xEn: store status, go to SKIP_D1 with 2 data bytes.
  - 0xCn/0xDn: store status, go to SKIP_D1 with 1 data byte.
  - 0xF0: clear running status, go to SYSEX.
  - 0xF1-0xF7: clear running status, go to IDLE.
  - Status arriving while in NOTE_D2, or in SKIP_D2 with a 2-byte skip pending: abort the partial message, pulse Err the cycle after, and still adopt the new status.
- Data handling:
  - IDLE: discard, pulse Err.
  - NOTE_D1: latch pitch, go to NOTE_D2.
  - NOTE_D2: form the message, then return to NOTE_D1 (running status).
    - Velocity = data for 0x9n, 0x00 for 0x8n.
    - If chan < NUM_CH: MIDI_msg <= {chan, pitch, vel} and Msg_valid=1.
    - Else: Drop=1 and MIDI_msg unchanged.
  - SKIP states: count down the data bytes, then return to SKIP_D1 (running status retained).
  - SYSEX: discard, no Err.
- Latency: MIDI_msg and Msg_valid update on the clock edge after the Rx_valid cycle carrying the final data byte. Registered outputs; no combinational path from Rx_data to outputs.
- MIDI_msg is stable between Msg_valid pulses. The downstream demux samples every cycle, so this stability is mandatory.
- Velocity-0 Note On passes through unchanged as velocity 0.
- At most one of Msg_valid/Err/Drop is asserted in any cycle.

Decomposition:
- Shared package midi_pkg:
  - state encoding.
  - status nibble constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CC=4'hB, PROG=4'hC, CH_AT=4'hD, BEND=4'hE.
  - SYSEX_START=8'hF0, SYSEX_END=8'hF7, RT_MIN=8'hF8.
  - message field offsets: CHAN=19:16, PITCH=15:8, VEL=7:0.
- One sub-module is natural: midi_byte_classify, a combinational decode of Rx_data into {is_data, is_chan_status, is_common, is_realtime, skip_len}.
- The FSM stays in midi_msg_parser.

Test Plan:
- Bytes 0x92,0x3C,0x64 → one cycle after the 0x64 strobe, MIDI_msg=20'h23C64 and Msg_valid=1 for exactly one cycle.
- Running status: 0x90,0x40,0x7F,0x41,0x00 → two messages, 20'h0407F then 20'h04100.
- Note Off 0x85,0x30,0x55 → MIDI_msg=20'h53000 (velocity forced to 0).
- 0x91,0x3C,0xF8,0x50 → 0xF8 ignored; MIDI_msg=20'h13C50 with no Err.
- Channel filter and error paths:
  - NUM_CH=8: 0x9A,0x3C,0x40 → Drop pulse, MIDI_msg holds previous value.
  - Data 0x3C in IDLE → Err pulse.
  - 0x90,0x3C,0xB0 → Err pulse, then 0x07,0x64 consumed silently.
- SysEx 0xF0,0x7E,0x01,0xF7 then 0x40 → no output; the trailing 0x40 raises Err (running status cleared).
- Assert Rst_n=0 between 0x93 and 0x3C → all outputs 0 immediately, and 0x3C after release raises Err.
